// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one read per PC value, captures the word into IR and
// offers it with pre-decoded fields to the controller through a valid/take handshake.
module fetch_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pc_in,
    input  logic        flush,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        loadpc,
    output logic [15:0] ir_out,
    output logic        ir_valid,
    input  logic        ir_take,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic        halted,
    output logic        fetch_err
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
    localparam logic [2:0] OpHalt     = 3'b111;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold,
        StHalt
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StReq;
            mem_addr  <= 8'h00;
            mem_rd    <= 1'b0;
            loadpc    <= 1'b0;
            ir_out    <= 16'h0000;
            ir_valid  <= 1'b0;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
            wait_cnt  <= 8'h00;
        end else begin
            loadpc <= 1'b0;
            // A flush outranks any completion, so a coincident mem_ready is dropped here.
            if (flush && state != StHalt) begin
                mem_rd   <= 1'b0;
                ir_valid <= 1'b0;
                wait_cnt <= 8'h00;
                state    <= StReq;
            end else begin
                unique case (state)
                    StReq: begin
                        mem_addr <= pc_in;
                        mem_rd   <= 1'b1;
                        wait_cnt <= 8'h00;
                        state    <= StWait;
                    end
                    StWait: begin
                        if (mem_ready) begin
                            ir_out   <= mem_rdata;
                            ir_valid <= 1'b1;
                            loadpc   <= 1'b1;
                            mem_rd   <= 1'b0;
                            wait_cnt <= 8'h00;
                            state    <= StHold;
                        end else if (wait_cnt == TimeoutCnt) begin
                            mem_rd    <= 1'b0;
                            fetch_err <= 1'b1;
                            halted    <= 1'b1;
                            wait_cnt  <= 8'h00;
                            state     <= StHalt;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                    StHold: begin
                        if (ir_take) begin
                            ir_valid <= 1'b0;
                            if (ir_out[15:13] == OpHalt) begin
                                halted <= 1'b1;
                                state  <= StHalt;
                            end else begin
                                state <= StReq;
                            end
                        end
                    end
                    StHalt: begin
                        // Only reset leaves this state.
                    end
                endcase
            end
        end
    end

    assign opcode = ir_out[15:13];
    assign op     = ir_out[12:11];
    assign rn     = ir_out[10:8];
    assign rd     = ir_out[7:5];
    assign sh     = ir_out[4:3];
    assign rm     = ir_out[2:0];
    assign sximm8 = {{8{ir_out[7]}}, ir_out[7:0]};
    assign sximm5 = {{11{ir_out[4]}}, ir_out[4:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetches are queued as expectations and a monitor
// checks each accepted fetch (loadpc pulse) against the queue head.
module tb_fetch_unit;

    localparam int unsigned TOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pc_in;
    logic        flush;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        loadpc;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_take = 1'b0;
    logic [2:0]  opcode, rn, rd, rm;
    logic [1:0]  op, sh;
    logic [15:0] sximm8, sximm5;
    logic        halted, fetch_err;

    // Bench-side controls
    logic        flush_req = 1'b0;
    logic        flush_on_ready = 1'b0;
    logic [7:0]  flush_target = 8'h00;
    logic        mem_never = 1'b0;
    int          mem_wait = 0;
    int          wcnt = 0;
    logic [15:0] memory [256];

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] ir;
        logic        chk;
        logic [2:0]  opcode, rn, rd, rm;
        logic [1:0]  op, sh;
        logic [15:0] sximm8, sximm5;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_loadpc = 0;
    int   cyc = 0;
    int   rd_cycles = 0;

    fetch_unit #(.TIMEOUT(TOUT)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .flush(flush),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .loadpc(loadpc), .ir_out(ir_out), .ir_valid(ir_valid), .ir_take(ir_take),
        .opcode(opcode), .op(op), .rn(rn), .rd(rd), .sh(sh), .rm(rm),
        .sximm8(sximm8), .sximm5(sximm5), .halted(halted), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    always_comb flush = flush_req | (flush_on_ready & mem_ready);

    // Program counter model: reset to 0, branch target on flush, increment on loadpc.
    always @(posedge clk) begin
        if (reset)       pc_in <= 8'h00;
        else if (flush)  pc_in <= flush_target;
        else if (loadpc) pc_in <= pc_in + 8'd1;
    end

    // Memory model: completes on the (mem_wait+1)-th WAIT cycle.
    always @(negedge clk) begin
        if (mem_rd && !mem_never && wcnt == mem_wait) begin
            mem_ready <= 1'b1;
            mem_rdata <= memory[mem_addr];
        end else begin
            mem_ready <= 1'b0;
            mem_rdata <= 16'h0000;
        end
        wcnt <= mem_rd ? wcnt + 1 : 0;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [7:0] a, input logic [15:0] w);
        exp_t e;
        e = '{addr: a, ir: w, chk: 1'b0, opcode: 3'd0, rn: 3'd0, rd: 3'd0, rm: 3'd0,
              op: 2'd0, sh: 2'd0, sximm8: 16'h0, sximm5: 16'h0};
        return e;
    endfunction

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_rd === 1'b1) rd_cycles++;
            if (!reset && loadpc === 1'b1) begin
                n_loadpc++;
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_addr", 32'(mem_addr), 32'(e.addr));
                    check("sb_ir", 32'(ir_out), 32'(e.ir));
                    check("sb_ir_valid", 32'(ir_valid), 32'd1);
                    if (e.chk) begin
                        check("sb_opcode", 32'(opcode), 32'(e.opcode));
                        check("sb_op", 32'(op), 32'(e.op));
                        check("sb_rn", 32'(rn), 32'(e.rn));
                        check("sb_rd", 32'(rd), 32'(e.rd));
                        check("sb_sh", 32'(sh), 32'(e.sh));
                        check("sb_rm", 32'(rm), 32'(e.rm));
                        check("sb_sximm8", 32'(sximm8), 32'(e.sximm8));
                        check("sb_sximm5", 32'(sximm5), 32'(e.sximm5));
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        exp_t e;
        int   errs;
        int   rd2, c3;
        logic snap2, snap3;

        for (int i = 0; i < 256; i++) memory[i] = 16'h0000;
        memory[8'h00] = 16'hD0A5;
        memory[8'h01] = 16'h2101;
        memory[8'h02] = 16'h4202;
        memory[8'h03] = 16'h6303;
        memory[8'h04] = 16'h1234;
        memory[8'h40] = 16'hA5D3;
        memory[8'h41] = 16'hE000;

        tick(); tick();
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_rd", 32'(mem_rd), 32'h0);
        check("rst_loadpc", 32'(loadpc), 32'h0);
        check("rst_ir_out", 32'(ir_out), 32'h0);
        check("rst_ir_valid", 32'(ir_valid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_fetch_err", 32'(fetch_err), 32'h0);
        check("rst_sximm8", 32'(sximm8), 32'h0);

        // Zero-wait fetch of D0A5, take delayed 5 cycles
        e = mk(8'h00, 16'hD0A5);
        e.chk = 1'b1; e.opcode = 3'd6; e.op = 2'd2; e.rn = 3'd0; e.rd = 3'd5; e.sh = 2'd0;
        e.rm = 3'd5; e.sximm8 = 16'hFFA5; e.sximm5 = 16'h0005;
        exp_q.push_back(e);
        reset = 1'b0;
        tick();
        check("t1_mem_rd", 32'(mem_rd), 32'h1);
        check("t1_mem_addr", 32'(mem_addr), 32'h00);
        check("t1_valid_early", 32'(ir_valid), 32'h0);
        tick();
        check("t1_ir_valid", 32'(ir_valid), 32'h1);
        check("t1_loadpc", 32'(loadpc), 32'h1);
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ir_valid !== 1'b1 || ir_out !== 16'hD0A5 || mem_rd !== 1'b0 || loadpc !== 1'b0)
                errs++;
        end
        check("t3_hold_stable", 32'(errs), 32'd0);
        check("t1_one_loadpc", 32'(n_loadpc), 32'd1);

        // Three wait states, take held high
        mem_wait = 3;
        exp_q.push_back(mk(8'h01, 16'h2101));
        exp_q.push_back(mk(8'h02, 16'h4202));
        exp_q.push_back(mk(8'h03, 16'h6303));
        ir_take = 1'b1;
        tick();
        check("t3_valid_drop", 32'(ir_valid), 32'h0);
        check("t3_no_rd_yet", 32'(mem_rd), 32'h0);
        tick();
        check("t3_rd_after_take", 32'(mem_rd), 32'h1);
        check("t2_addr1", 32'(mem_addr), 32'h01);
        snap2 = 1'b0; snap3 = 1'b0; rd2 = 0; c3 = 0;
        for (int i = 0; i < 200 && n_loadpc < 4; i++) begin
            tick();
            if (n_loadpc == 2 && !snap2) begin snap2 = 1'b1; rd2 = rd_cycles; end
            if (n_loadpc == 3 && !snap3) begin snap3 = 1'b1; c3 = cyc; end
        end
        ir_take = 1'b0;
        check("t2_done", 32'(n_loadpc), 32'd4);
        check("t2_rd_cycles", 32'(rd_cycles - rd2), 32'd8);
        check("t2_period", 32'(cyc - c3), 32'd6);

        // Flush coincident with mem_ready on the fetch from 04
        tick(); tick();
        check("t4_still_held", 32'(ir_valid), 32'h1);
        mem_wait = 2;
        flush_target = 8'h40;
        e = mk(8'h40, 16'hA5D3);
        e.chk = 1'b1; e.opcode = 3'd5; e.op = 2'd0; e.rn = 3'd5; e.rd = 3'd6; e.sh = 2'd2;
        e.rm = 3'd3; e.sximm8 = 16'hFFD3; e.sximm5 = 16'hFFF3;
        exp_q.push_back(e);
        e = mk(8'h41, 16'hE000);
        e.chk = 1'b1; e.opcode = 3'd7;
        exp_q.push_back(e);
        ir_take = 1'b1;
        flush_on_ready = 1'b1;
        for (int i = 0; i < 20 && mem_ready !== 1'b1; i++) tick();
        check("t4_ready_seen", 32'(mem_ready), 32'h1);
        check("t4_addr04", 32'(mem_addr), 32'h04);
        tick();
        flush_on_ready = 1'b0;
        check("t4_ir_kept", 32'(ir_out), 32'h6303);
        check("t4_no_loadpc", 32'(loadpc), 32'h0);
        check("t4_valid_clr", 32'(ir_valid), 32'h0);
        check("t4_rd_clr", 32'(mem_rd), 32'h0);
        check("t4_loadpc_cnt", 32'(n_loadpc), 32'd4);
        tick();
        check("t4_req_rd", 32'(mem_rd), 32'h1);
        check("t4_addr40", 32'(mem_addr), 32'h40);

        // Halt instruction at 41
        for (int i = 0; i < 100 && halted !== 1'b1; i++) tick();
        check("t5_halted", 32'(halted), 32'h1);
        check("t5_loadpc_cnt", 32'(n_loadpc), 32'd6);
        check("t5_opcode", 32'(opcode), 32'd7);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            flush_req = (i == 10);
            tick();
            if (mem_rd !== 1'b0 || halted !== 1'b1) errs++;
        end
        flush_req = 1'b0;
        ir_take = 1'b0;
        check("t5_halt_quiet", 32'(errs), 32'd0);
        check("t5_no_err", 32'(fetch_err), 32'h0);

        reset = 1'b1;
        tick();
        check("t5_rst_halted", 32'(halted), 32'h0);
        check("t5_rst_ir", 32'(ir_out), 32'h0);
        check("t5_rst_addr", 32'(mem_addr), 32'h0);
        check("t5_rst_valid", 32'(ir_valid), 32'h0);
        check("t5_rst_opcode", 32'(opcode), 32'h0);

        // Timeout: no mem_ready ever
        mem_never = 1'b1;
        reset = 1'b0;
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_rd !== 1'b1 || fetch_err !== 1'b0 || halted !== 1'b0) errs++;
        end
        check("t6_wait_cycles", 32'(errs), 32'd0);
        tick();
        check("t6_fetch_err", 32'(fetch_err), 32'h1);
        check("t6_halted", 32'(halted), 32'h1);
        check("t6_rd_drop", 32'(mem_rd), 32'h0);

        // mem_ready on the last WAIT cycle wins over the timeout
        reset = 1'b1;
        mem_never = 1'b0;
        mem_wait = 4;
        exp_q.push_back(mk(8'h00, 16'hD0A5));
        tick();
        check("t6_rst_err", 32'(fetch_err), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        tick();
        check("t6_late_valid", 32'(ir_valid), 32'h1);
        check("t6_late_loadpc", 32'(loadpc), 32'h1);
        check("t6_late_no_err", 32'(fetch_err), 32'h0);
        check("t6_late_not_halted", 32'(halted), 32'h0);
        tick(); tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("total_loadpc", 32'(n_loadpc), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit RISC datapath. Consumes the 8-bit program counter value, issues a read to instruction memory with a ready handshake, and latches the returned word into the instruction register (IR). Presents IR plus pre-decoded fields to the controller with a valid/take handshake. Pulses `loadpc` back to the program counter once per accepted fetch.

## Interface
- `TIMEOUT`, 15: maximum cycles spent in WAIT before a fetch error; legal range 1..255.
- `clk`  in  1  single system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`.
- `pc_in`  in  8  current program counter value.
- `flush`  in  1  discard any in-flight or held instruction and refetch (branch taken).
- `mem_addr`  out  8  instruction memory address, registered.
- `mem_rd`  out  1  read request, held until `mem_ready`, `flush` or timeout.
- `mem_rdata`  in  16  instruction word, valid when `mem_rd` and `mem_ready` are both high.
- `mem_ready`  in  1  memory completion strobe.
- `loadpc`  out  1  one-cycle pulse: increment program counter.
- `ir_out`  out  16  instruction register.
- `ir_valid`  out  1  `ir_out` and the decoded fields are valid.
- `ir_take`  in  1  controller accepts the held instruction.
- `opcode`  out  3  `ir_out[15:13]`.
- `op`  out  2  `ir_out[12:11]`.
- `rn`  out  3  `ir_out[10:8]`.
- `rd`  out  3  `ir_out[7:5]`.
- `sh`  out  2  `ir_out[4:3]`.
- `rm`  out  3  `ir_out[2:0]`.
- `sximm8`  out  16  `ir_out[7:0]` sign-extended.
- `sximm5`  out  16  `ir_out[4:0]` sign-extended.
- `halted`  out  1  HALT state reached.
- `fetch_err`  out  1  sticky; set on timeout.

## Operation
- States: REQ, WAIT, HOLD, HALT. Reset enters REQ.
- REQ: `mem_addr <= pc_in`, `mem_rd <= 1`, go WAIT. Always exactly one cycle.
- WAIT: `mem_rd` stays high, and `wait_cnt` increments each cycle.
  - On `mem_ready`: `ir_out <= mem_rdata`, `ir_valid <= 1`, `loadpc <= 1` for one cycle, `mem_rd <= 0`, `wait_cnt <= 0`, go HOLD.
  - If `wait_cnt == TIMEOUT` with no `mem_ready`: `mem_rd <= 0`, `fetch_err <= 1`, go HALT. `mem_ready` in that same cycle wins over the timeout.
- HOLD: `ir_valid` stays high and `ir_out` is stable until `ir_take`.
  - On `ir_take`: `ir_valid <= 0`.
  - If `opcode == 3'b111` (halt), go HALT; otherwise go REQ.
- HALT: `halted = 1`, no memory requests. Only `reset` exits HALT; `flush` is ignored.
- `flush` priority: `reset` > `flush` > `mem_ready`/timeout > `ir_take`. In REQ, WAIT or HOLD, `flush` clears `mem_rd`, `ir_valid`, `loadpc` and `wait_cnt`, and the next state is REQ.
  - A `mem_ready` coincident with `flush` is discarded: IR is not updated and there is no `loadpc` pulse.
- Decoded fields are purely combinational from `ir_out`. Sign extension replicates bit 7 (for `sximm8`) or bit 4 (for `sximm5`) into the upper bits.
- Reset values: `mem_addr = 0`, `mem_rd = 0`, `loadpc = 0`, `ir_out = 0`, `ir_valid = 0`, `halted = 0`, `fetch_err = 0`, `wait_cnt = 0`. All decoded fields are therefore 0.
- Reset asserted mid-fetch drops the request on the next edge. A later `mem_ready` is ignored unless a new REQ has issued.

## Timing
- Edge E0 in REQ samples `pc_in`. `mem_rd` is high from E0 until the capture edge.
- Zero-wait memory (`mem_ready` high in the first WAIT cycle): capture at E1. `ir_valid` and `loadpc` are high after E1.
- The program counter increments at E2, so `pc_in` is updated before the next REQ samples it.
- If `ir_take` is high in the first cycle of `ir_valid`, HOLD lasts one cycle: REQ at E2, sample at E3.
- Throughput: one instruction per 3 cycles plus memory wait states plus controller stall cycles.
- Timeout: `mem_rd` with no `mem_ready` for `TIMEOUT+1` WAIT cycles raises `fetch_err` and `halted` on the following edge.

## Test plan
- Reset, then `pc_in = 8'h00`, zero-wait memory returning `16'hD0A5`: `mem_addr = 00`; `ir_valid` 2 cycles after reset deassert; `opcode = 6`, `op = 2`, `rn = 0`, `rd = 5`, `rm = 5`; `sximm8 = FFA5`, `sximm5 = 0005`; exactly one `loadpc` pulse.
- Memory with 3 wait states and `ir_take` held high: `mem_rd` high for 4 cycles; consecutive `mem_addr` values 00, 01, 02 track `pc_in`; exactly one `loadpc` per instruction.
- `ir_take` delayed 5 cycles: `ir_out` stable, `ir_valid` high throughout, no new `mem_rd` until one cycle after take.
- `flush` in the same cycle as `mem_ready` (data `16'h1234`): IR keeps its old value, no `loadpc` pulse, REQ next cycle; a subsequent fetch from new `pc_in = 8'h40` shows `mem_addr = 40`.
- Fetch returns `16'hE000` and is taken: `halted = 1`, `mem_rd` stays 0 for 20 cycles, and `flush` has no effect; `reset` returns to REQ with all outputs 0.
- `TIMEOUT = 4`, `mem_ready` never asserted: `fetch_err` and `halted` set after 5 WAIT cycles; a `mem_ready` on the 5th WAIT cycle instead completes the fetch normally with `fetch_err = 0`.
